// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master receive path.
// Also holds the majority vote used by the optional SDA glitch filter (I2C_RX_GLITCH_FILTER_EN).
package i2c_pkg;

  localparam int I2C_MAX_BYTES = 8;
  localparam int I2C_BYTE_W    = 8;
  localparam int I2C_IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_ACK_SETUP = 2'd2,
    ST_ACK_HOLD  = 2'd3
  } i2c_rx_state_t;

  // v[0] is the live SDA level; a 2/2 tie follows the live level
  function automatic logic maj4(input logic [3:0] v);
    logic [2:0] ones;
    ones = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    if (ones >= 3'd3) begin
      return 1'b1;
    end else if (ones <= 3'd1) begin
      return 1'b0;
    end else begin
      return v[0];
    end
  endfunction

endpackage

// File: rtl/i2c_rx_byte_engine_chk.sv
// Protocol checker for the receive engine: SCL strobes must never coincide.
module i2c_rx_byte_engine_chk (
  input logic Clock,
  input logic nReset,
  input logic SclRise,
  input logic SclFall
);

  a_no_dual_scl_edge: assert property (@(posedge Clock) disable iff (!nReset)
    !(SclRise && SclFall));

endmodule

// File: rtl/i2c_rx_shift8.sv
// Serial-in/parallel-out byte shifter with its bit counter.
// Full flags the shift that completes a byte; ByteOut is the byte including that bit.
module i2c_rx_shift8
  import i2c_pkg::*;
(
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  Clear,
  input  logic                  ShiftEn,
  input  logic                  SdaBit,
  output logic                  Full,
  output logic [I2C_BYTE_W-1:0] ByteOut
);

  // only the first seven bits are stored; the eighth goes straight to ByteOut
  logic [I2C_BYTE_W-2:0] sr_r;
  logic [2:0]            cnt_r;

  // shift register and bit counter, clear has priority over shift
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sr_r  <= 7'h00;
      cnt_r <= 3'd0;
    end else if (Clear) begin
      sr_r  <= 7'h00;
      cnt_r <= 3'd0;
    end else if (ShiftEn) begin
      sr_r  <= {sr_r[5:0], SdaBit};
      cnt_r <= cnt_r + 3'd1;
    end else begin
      sr_r  <= sr_r;
      cnt_r <= cnt_r;
    end
  end

  assign Full    = ShiftEn & (cnt_r == 3'd7);
  assign ByteOut = {sr_r, SdaBit};

endmodule

// File: rtl/i2c_rx_byte_engine.sv
// I2C master receive byte engine: samples SDA on SCL rise strobes, assembles bytes MSB first,
// drives ACK/NACK and hands bytes downstream. Optional SDA filter: I2C_RX_GLITCH_FILTER_EN.
module i2c_rx_byte_engine
  import i2c_pkg::*;
#(
  parameter int MAX_BYTES = I2C_MAX_BYTES
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [3:0]            Length,
  input  logic                  SclRise,
  input  logic                  SclFall,
  input  logic                  SdaIn,
  output logic                  SdaDrive,
  output logic [I2C_BYTE_W-1:0] ByteData,
  output logic                  ByteValid,
  output logic [I2C_IDX_W-1:0]  ByteIndex,
  output logic                  Busy,
  output logic                  Done
);

  i2c_rx_state_t         state_r, state_n_s;
  logic [3:0]            rem_r;
  logic [I2C_IDX_W-1:0]  idx_r;
  logic [I2C_BYTE_W-1:0] byte_data_r;
  logic                  byte_valid_r, done_r, sda_r;

  logic rise_s, fall_s, sample_s, last_s;
  logic shift_en_s, full_s, clr_s;
  logic start_acc_s, byte_load_s, ack_set_s, ack_rel_s, next_byte_s, done_s;
  logic [3:0]            len_clamp_s;
  logic [I2C_BYTE_W-1:0] byte_s;

  // coincident strobes are a protocol error and are both dropped
  assign rise_s      = SclRise & ~SclFall;
  assign fall_s      = SclFall & ~SclRise;
  assign last_s      = (rem_r == 4'd1);
  assign len_clamp_s = (Length > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : Length;
  assign shift_en_s  = (state_r == ST_SHIFT) & rise_s & ~Abort;

`ifdef I2C_RX_GLITCH_FILTER_EN
  logic [2:0] hist_r;

  // SDA history for the majority vote
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      hist_r <= 3'b111;
    end else begin
      hist_r <= {hist_r[1:0], SdaIn};
    end
  end

  assign sample_s = maj4({hist_r, SdaIn});
`else
  assign sample_s = SdaIn;
`endif

  i2c_rx_shift8 u_shift8 (
    .Clock   (Clock),
    .nReset  (nReset),
    .Clear   (clr_s),
    .ShiftEn (shift_en_s),
    .SdaBit  (sample_s),
    .Full    (full_s),
    .ByteOut (byte_s)
  );

  // state register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // next state and datapath controls; Abort overrides every other event
  always_comb begin
    state_n_s   = state_r;
    clr_s       = 1'b0;
    start_acc_s = 1'b0;
    byte_load_s = 1'b0;
    ack_set_s   = 1'b0;
    ack_rel_s   = 1'b0;
    next_byte_s = 1'b0;
    done_s      = 1'b0;
    if (Abort) begin
      state_n_s = ST_IDLE;
      clr_s     = 1'b1;
      ack_rel_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            start_acc_s = 1'b1;
            clr_s       = 1'b1;
            if (len_clamp_s == 4'd0) begin
              done_s = 1'b1;
            end else begin
              state_n_s = ST_SHIFT;
            end
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (full_s) begin
            byte_load_s = 1'b1;
            state_n_s   = ST_ACK_SETUP;
          end else begin
            state_n_s = ST_SHIFT;
          end
        end
        ST_ACK_SETUP: begin
          if (fall_s) begin
            ack_set_s = 1'b1;
            state_n_s = ST_ACK_HOLD;
          end else begin
            state_n_s = ST_ACK_SETUP;
          end
        end
        ST_ACK_HOLD: begin
          if (fall_s) begin
            ack_rel_s = 1'b1;
            if (last_s) begin
              done_s    = 1'b1;
              state_n_s = ST_IDLE;
            end else begin
              next_byte_s = 1'b1;
              clr_s       = 1'b1;
              state_n_s   = ST_SHIFT;
            end
          end else begin
            state_n_s = ST_ACK_HOLD;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
        end
      endcase
    end
  end

  // output registers, byte/remaining counters and the ACK drive
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rem_r        <= 4'd0;
      idx_r        <= '0;
      byte_data_r  <= 8'h00;
      byte_valid_r <= 1'b0;
      done_r       <= 1'b0;
      sda_r        <= 1'b0;
    end else begin
      byte_valid_r <= byte_load_s;
      done_r       <= done_s;
      if (byte_load_s) begin
        byte_data_r <= byte_s;
      end else begin
        byte_data_r <= byte_data_r;
      end
      if (start_acc_s) begin
        rem_r <= len_clamp_s;
        idx_r <= '0;
      end else if (next_byte_s) begin
        rem_r <= rem_r - 4'd1;
        idx_r <= idx_r + 3'd1;
      end else begin
        rem_r <= rem_r;
        idx_r <= idx_r;
      end
      if (ack_set_s) begin
        sda_r <= ~last_s;
      end else if (ack_rel_s) begin
        sda_r <= 1'b0;
      end else begin
        sda_r <= sda_r;
      end
    end
  end

  i2c_rx_byte_engine_chk u_chk (
    .Clock   (Clock),
    .nReset  (nReset),
    .SclRise (SclRise),
    .SclFall (SclFall)
  );

  assign SdaDrive  = sda_r;
  assign ByteData  = byte_data_r;
  assign ByteValid = byte_valid_r;
  assign ByteIndex = idx_r;
  assign Done      = done_r;
  assign Busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_i2c_rx_byte_engine.sv
// Self-checking bench for i2c_rx_byte_engine: directed test-plan transfers plus randomized
// transfers, aborts and async resets, checked against per-byte expectations from the data.
module tb_i2c_rx_byte_engine;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic [3:0] Length = 4'd0;
  logic       SclRise = 1'b0;
  logic       SclFall = 1'b0;
  logic       SdaIn = 1'b1;
  logic       SdaDrive;
  logic [7:0] ByteData;
  logic       ByteValid;
  logic [2:0] ByteIndex;
  logic       Busy;
  logic       Done;

  int vec_cnt = 0;
  int err_cnt = 0;
  int valid_seen = 0;
  int done_seen = 0;
  logic [7:0] last_byte = 8'h00;

  always #5 Clock = ~Clock;

  i2c_rx_byte_engine #(.MAX_BYTES(8)) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .Start     (Start),
    .Abort     (Abort),
    .Length    (Length),
    .SclRise   (SclRise),
    .SclFall   (SclFall),
    .SdaIn     (SdaIn),
    .SdaDrive  (SdaDrive),
    .ByteData  (ByteData),
    .ByteValid (ByteValid),
    .ByteIndex (ByteIndex),
    .Busy      (Busy),
    .Done      (Done)
  );

  // pulse counters, so spurious ByteValid/Done pulses are caught too
  always @(negedge Clock) begin
    if (ByteValid) valid_seen++;
    if (Done) done_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // kind: 0 none, 1 Abort before rise of bit stop_bit (8 = in ACK_HOLD), 2 async reset in ACK_HOLD
  task automatic run_xfer(input logic [3:0] len, input logic [63:0] data, input int kind,
                          input int stop_byte, input int stop_bit, input bit glitch7);
    int n;
    int v0;
    int d0;
    logic [7:0] b;
    logic [7:0] exp_b;
    n  = (len > 4'd8) ? 8 : int'(len);
    v0 = valid_seen;
    d0 = done_seen;
    Length = len;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
    if (n == 0) begin
      check_eq("len0_done", Done, 1);
      check_eq("len0_busy", Busy, 0);
      tick();
      check_eq("len0_done_once", Done, 0);
      check_eq("len0_sda", SdaDrive, 0);
      return;
    end
    check_eq("busy_after_start", Busy, 1);
    for (int k = 0; k < n; k++) begin
      b     = data[8*k +: 8];
      exp_b = b;
      for (int i = 7; i >= 0; i--) begin
        SdaIn = b[i];
        idle($urandom_range(4, 6));
        if (kind == 1 && k == stop_byte && i == stop_bit) begin
          Abort = 1'b1;
          tick();
          Abort = 1'b0;
          check_eq("abort_busy", Busy, 0);
          check_eq("abort_sda", SdaDrive, 0);
          check_eq("abort_hold_data", ByteData, last_byte);
          tick();
          check_eq("abort_valid_count", valid_seen - v0, k);
          check_eq("abort_no_done", done_seen - d0, 0);
          return;
        end
        if (glitch7 && i == 7) SdaIn = 1'b0;
        SclRise = 1'b1;
        tick();
        SclRise = 1'b0;
        SdaIn   = b[i];
        if (i == 0) begin
`ifdef I2C_RX_GLITCH_FILTER_EN
          exp_b = b;
`else
          if (glitch7) exp_b = {1'b0, b[6:0]};
`endif
          check_eq("byte_valid", ByteValid, 1);
          check_eq("byte_data", ByteData, exp_b);
          check_eq("byte_index", ByteIndex, k);
          last_byte = exp_b;
        end
        idle($urandom_range(1, 3));
        SclFall = 1'b1;
        tick();
        SclFall = 1'b0;
      end
      check_eq("ack_drive", SdaDrive, (k != n - 1));
      if ((kind == 1 || kind == 2) && k == stop_byte && stop_bit == 8) begin
        if (kind == 1) begin
          Abort = 1'b1;
          tick();
          Abort = 1'b0;
          check_eq("abort_ack_sda", SdaDrive, 0);
          check_eq("abort_ack_busy", Busy, 0);
          check_eq("abort_ack_data", ByteData, last_byte);
          tick();
          check_eq("abort_ack_no_done", done_seen - d0, 0);
        end else begin
          nReset = 1'b0;
          #1;
          check_eq("rst_async_sda", SdaDrive, 0);
          check_eq("rst_async_busy", Busy, 0);
          check_eq("rst_async_data", ByteData, 8'h00);
          #2;
          nReset    = 1'b1;
          last_byte = 8'h00;
          tick();
        end
        return;
      end
      SdaIn = 1'b1;
      idle(3);
      SclRise = 1'b1;
      tick();
      SclRise = 1'b0;
      check_eq("ack_hold", SdaDrive, (k != n - 1));
      idle(2);
      SclFall = 1'b1;
      tick();
      SclFall = 1'b0;
      check_eq("ack_release", SdaDrive, 0);
      check_eq("done_pulse", Done, (k == n - 1));
      check_eq("busy_after_ack", Busy, (k != n - 1));
    end
    tick();
    check_eq("done_cleared", Done, 0);
    check_eq("valid_count", valid_seen - v0, n);
    check_eq("done_count", done_seen - d0, 1);
  endtask

  initial begin
    logic [3:0]  len;
    logic [63:0] data;
    int          kind;
    int          sb;
    int          sbit;

    #3;
    check_eq("rst_sda", SdaDrive, 0);
    check_eq("rst_data", ByteData, 8'h00);
    check_eq("rst_valid", ByteValid, 0);
    check_eq("rst_index", ByteIndex, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    #10;
    nReset = 1'b1;
    idle(2);

    run_xfer(4'd1, 64'h00000000000000A5, 0, 0, 0, 1'b0);
    run_xfer(4'd3, 64'h0000000000563412, 0, 0, 0, 1'b0);
    run_xfer(4'd0, 64'h0, 0, 0, 0, 1'b0);
    run_xfer(4'd12, {$urandom(), $urandom()}, 0, 0, 0, 1'b0);
    run_xfer(4'd2, {$urandom(), $urandom()}, 1, 0, 8, 1'b0);
    run_xfer(4'd1, {$urandom(), $urandom()}, 0, 0, 0, 1'b0);
    run_xfer(4'd1, 64'h00000000000000FF, 0, 0, 0, 1'b1);
    run_xfer(4'd3, {$urandom(), $urandom()}, 2, 1, 8, 1'b0);

    for (int t = 0; t < 16; t++) begin
      len  = 4'($urandom_range(0, 15));
      data = {$urandom(), $urandom()};
      kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
      sb   = (len > 4'd8) ? $urandom_range(0, 7) : $urandom_range(0, (len == 4'd0) ? 0 : int'(len) - 1);
      sbit = $urandom_range(0, 8);
      run_xfer(len, data, kind, sb, sbit, 1'b0);
      idle($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
